// File: rtl/seg_pkg.sv
// seg_pkg
// Shared constants and types for the seven-segment scan driver.
// Contents:
//   GLYPH_0..GLYPH_F : active-low segment patterns, bit order g..a (bit 0 = a).
//                      'b' and 'd' are lowercase glyphs.
//   SEG_BLANK        : all segments off.
//   NUM_DIGITS       : digit positions per frame (8).
//   IDX_W            : width of the digit index (3).
//   LAST_IDX         : index of the final digit in a frame.
//   snap_t           : frame snapshot of digit data, decimal points and blanking.
package seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
  } snap_t;

endpackage

// File: rtl/hex7seg_enc.sv
// hex7seg_enc
// Combinational hex nibble to seven-segment encoder, active-low outputs.
// Ports:
//   nibble : 4-bit hex value to display.
//   seg_n  : segments g..a (bit 0 = a), 0 lights a segment.
module hex7seg_enc
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Straight lookup of the glyph table; every nibble value has a glyph.
  always_comb begin
    seg_n = SEG_BLANK;
    case (nibble)
      4'h0: seg_n = GLYPH_0;
      4'h1: seg_n = GLYPH_1;
      4'h2: seg_n = GLYPH_2;
      4'h3: seg_n = GLYPH_3;
      4'h4: seg_n = GLYPH_4;
      4'h5: seg_n = GLYPH_5;
      4'h6: seg_n = GLYPH_6;
      4'h7: seg_n = GLYPH_7;
      4'h8: seg_n = GLYPH_8;
      4'h9: seg_n = GLYPH_9;
      4'hA: seg_n = GLYPH_A;
      4'hB: seg_n = GLYPH_B;
      4'hC: seg_n = GLYPH_C;
      4'hD: seg_n = GLYPH_D;
      4'hE: seg_n = GLYPH_E;
      4'hF: seg_n = GLYPH_F;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed scan driver for an 8-digit seven-segment display feeding a
// 74LS138-style 3-to-8 decoder. Input values are captured once per frame so a
// frame never mixes old and new data.
// Parameters:
//   CLK_DIV : clock cycles per digit slot (>= 2).
//   GUARD   : dark cycles at the start of each slot (1 <= GUARD < CLK_DIV);
//             used only when SEG_SCAN_GHOST_BLANK_EN is defined.
// Ports:
//   clk, rst            : clock and synchronous active-high reset.
//   en                  : scan enable; low freezes the scan and darkens the display.
//   digit_data[31:0]    : nibble i is digit i.
//   dp[7:0], blank[7:0] : per-digit decimal point / blanking, active-high.
//   sel_a[2:0], sel_s1  : decoder address and main enable.
//   sel_s2_n, sel_s3_n  : decoder auxiliary enables, tied active.
//   seg_n[6:0], dp_n    : active-low segment and decimal-point drive.
//   frame_tick          : one-cycle pulse on the first slot of each frame.
// Build option:
//   SEG_SCAN_GHOST_BLANK_EN : hold sel_s1 low for the first GUARD cycles of
//                             every slot to suppress ghosting.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [IDX_W-1:0]        sel_a,
  output logic                    sel_s1,
  output logic                    sel_s2_n,
  output logic                    sel_s3_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX    = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GUARD_P = PW'(GUARD);

`ifdef SEG_SCAN_GHOST_BLANK_EN
  localparam bit GHOST_EN = 1'b1;
`else
  localparam bit GHOST_EN = 1'b0;
`endif

  logic [PW-1:0]    pcnt;
  logic [IDX_W-1:0] idx;
  snap_t            snap;
  logic             start_pending;

  logic             slot_end;
  logic             start_evt;
  logic [PW-1:0]    next_pcnt;
  logic [IDX_W-1:0] next_idx;
  logic [3:0]       enc_nibble;
  logic             enc_blank;
  logic             enc_dp;
  logic [6:0]       glyph;
  logic             guard_active;

  assign sel_a    = idx;
  assign sel_s2_n = 1'b0;
  assign sel_s3_n = 1'b0;

  assign slot_end  = (pcnt == PMAX);
  assign start_evt = en && (start_pending || (slot_end && (idx == LAST_IDX)));

  // Next slot position plus the digit source for the slot being entered.
  // A start event encodes straight from the live inputs because the snapshot
  // is being loaded on the same edge; everything else reads the snapshot, which
  // also re-encodes the frozen digit when scanning resumes after en drops.
  always_comb begin
    next_pcnt = pcnt + PW'(1);
    next_idx  = idx;
    if (start_evt) begin
      next_pcnt = '0;
      next_idx  = '0;
    end else if (slot_end) begin
      next_pcnt = '0;
      next_idx  = idx + IDX_W'(1);
    end

    enc_nibble = snap.data[{next_idx, 2'b00} +: 4];
    enc_blank  = snap.blank[next_idx];
    enc_dp     = snap.dp[next_idx];
    if (start_evt) begin
      enc_nibble = digit_data[3:0];
      enc_blank  = blank[0];
      enc_dp     = dp[0];
    end
  end

  assign guard_active = GHOST_EN && (next_pcnt < GUARD_P);

  hex7seg_enc u_enc (
    .nibble (enc_nibble),
    .seg_n  (glyph)
  );

  // All scan state and display outputs; address and segment data move on the
  // same edge so a new index is never paired with stale segments.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt          <= '0;
      idx           <= '0;
      snap          <= '0;
      start_pending <= 1'b1;
      sel_s1        <= 1'b0;
      seg_n         <= SEG_BLANK;
      dp_n          <= 1'b1;
      frame_tick    <= 1'b0;
    end else if (!en) begin
      sel_s1     <= 1'b0;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      pcnt       <= next_pcnt;
      idx        <= next_idx;
      sel_s1     <= !guard_active;
      seg_n      <= enc_blank ? SEG_BLANK : glyph;
      dp_n       <= enc_blank ? 1'b1 : !enc_dp;
      frame_tick <= start_evt;
      if (start_evt) begin
        snap.data     <= digit_data;
        snap.dp       <= dp;
        snap.blank    <= blank;
        start_pending <= 1'b0;
      end
    end
  end

endmodule
